// File: rtl/aes_output_serializer_pkg.sv
// Shared AES result-block definitions for the output serializer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_output_serializer_pkg;

  localparam int AES_BLOCK_BITS = 128;

  // Cipher state flattened MS byte first: byte 0 lives in [127:120].
  typedef logic [AES_BLOCK_BITS-1:0] state_t;

  // Number of output words needed to carry one block.
  function automatic int words_per_block(input int word_w);
    return AES_BLOCK_BITS / word_w;
  endfunction

endpackage

// File: rtl/aes_output_serializer_if.sv
// Block-in / word-out bus between the cipher pipeline, serializer and sink.
// Latency: n/a (wiring only).
// Backpressure: out_ready throttles words; the block side has no stall.
interface aes_output_serializer_if #(
  parameter int WORD_W = 32
);
  import aes_output_serializer_pkg::*;

  state_t              in_block;
  logic                in_valid;
  logic [WORD_W-1:0]   out_word;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  // Environment side: cipher pipeline plus downstream word consumer.
  modport master (
    output in_block, in_valid, out_ready,
    input  out_word, out_valid, out_last
  );

  // Serializer side.
  modport slave (
    input  in_block, in_valid, out_ready,
    output out_word, out_valid, out_last
  );

endinterface

// File: rtl/aes_block_fifo.sv
// DEPTH x 128-bit block store with push/pop, count and full/empty flags.
// Latency: a pushed block is visible on rd_data after the next edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module aes_block_fifo
  import aes_output_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  state_t           wr_data,
  input  logic             pop,
  output state_t           rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/aes_output_serializer.sv
// Buffers AES result blocks and streams each as WORD_W-bit words, MS slice first.
// Latency: 1 cycle from in_valid to out_valid when empty; no comb in-to-out path.
// Backpressure: out_ready stalls words; blocks arriving to a full FIFO are dropped and flagged.
module aes_output_serializer
  import aes_output_serializer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  aes_output_serializer_if.slave io,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int N     = words_per_block(WORD_W);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           head;
  state_t           shifted;
  logic             full;
  logic             empty;
  logic             xfer;
  logic             pop;
  logic             accept;
  logic             drop;
  logic [IDX_W-1:0] idx;

  // A block may enter a full FIFO only when the head block leaves in the same cycle.
  assign xfer   = io.out_valid & io.out_ready;
  assign pop    = xfer & io.out_last;
  assign accept = io.in_valid & !reset & (!full | pop);
  assign drop   = io.in_valid & !reset & !accept;

  aes_block_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept),
    .wr_data (io.in_block),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Word index within the head block; wraps on the last word.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
    end else if (xfer) begin
      idx <= io.out_last ? '0 : idx + 1'b1;
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Select slice idx of the head block, forced to zero when nothing is held.
  always_comb begin
    shifted     = head << (WORD_W * int'(idx));
    io.out_word = '0;
    if (io.out_valid) begin
      io.out_word = shifted[AES_BLOCK_BITS-1 -: WORD_W];
    end
  end

  assign io.out_valid = !empty;
  assign io.out_last  = io.out_valid & (idx == IDX_W'(N - 1));
  assign almost_full  = (fifo_count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_aes_output_serializer.sv
// Directed checks of the AES output serializer with DEPTH=4, WORD_W=32.
// Latency: n/a.
// Backpressure: exercised via out_ready stalls and a full FIFO.
module tb_aes_output_serializer;
  import aes_output_serializer_pkg::*;

  logic       clock;
  logic       reset;
  logic [2:0] fifo_count;
  logic       almost_full;
  logic       overflow;
  logic       clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [31:0] fips_w [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
  int          drain_order [4] = '{2, 3, 4, 6};

  aes_output_serializer_if #(.WORD_W(32)) bus ();

  aes_output_serializer #(
    .DEPTH  (4),
    .WORD_W (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io             (bus),
    .fifo_count     (fifo_count),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Word w of test block i: B000_0000 | i<<8 | w.
  function automatic logic [31:0] exp_word(input int i, input int w);
    return 32'hB000_0000 | (32'(i) << 8) | 32'(w);
  endfunction

  function automatic logic [127:0] mk(input int i);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[127 - 32*w -: 32] = exp_word(i, w);
    return r;
  endfunction

  initial begin
    reset          = 1'b1;
    clear_overflow = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_block   = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", bus.out_valid, 0);
    check("rst_word", bus.out_word, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_count", fifo_count, 0);
    check("rst_afull", almost_full, 0);
    check("rst_ovf", overflow, 0);

    // FIPS-197 block streams out on 4 consecutive cycles
    bus.out_ready = 1'b1;
    bus.in_block  = FIPS;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("fips_count1", fifo_count, 1);
    for (int w = 0; w < 4; w++) begin
      check("fips_valid", bus.out_valid, 1);
      check("fips_word", bus.out_word, fips_w[w]);
      check("fips_last", bus.out_last, (w == 3));
      tick();
    end
    check("fips_done_valid", bus.out_valid, 0);
    check("fips_done_count", fifo_count, 0);

    // Backpressure at idx=1
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp_w0", bus.out_word, fips_w[0]);
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_word", bus.out_word, fips_w[1]);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_last", bus.out_last, 0);
    end
    bus.out_ready = 1'b1;
    for (int w = 1; w < 4; w++) begin
      check("bp_resume_word", bus.out_word, fips_w[w]);
      tick();
    end
    check("bp_done_valid", bus.out_valid, 0);

    // Burst of 5 into a stalled FIFO
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_block = mk(i);
      bus.in_valid = 1'b1;
      tick();
      check("burst_count", fifo_count, (i < 4) ? i : 4);
      check("burst_afull", almost_full, (i >= 3));
      check("burst_ovf", overflow, (i == 5));
    end
    bus.in_valid = 1'b0;

    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clear_alone", overflow, 0);

    // Full FIFO: push alongside the pop of block 1's last word
    bus.out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      check("fullpop_word", bus.out_word, exp_word(1, w));
      if (w == 3) begin
        check("fullpop_last", bus.out_last, 1);
        bus.in_block = mk(6);
        bus.in_valid = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("fullpop_count", fifo_count, 4);
    check("fullpop_ovf", overflow, 0);

    // Drain: blocks 2,3,4,6 in order, block 5 absent
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        check("drain_word", bus.out_word, exp_word(drain_order[b], w));
        check("drain_last", bus.out_last, (w == 3));
        tick();
      end
    end
    check("drain_valid", bus.out_valid, 0);
    check("drain_count", fifo_count, 0);

    // Clear versus set in the same cycle
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_block = mk(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_block   = mk(7);
    clear_overflow = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    clear_overflow = 1'b0;
    check("setclr_ovf", overflow, 1);
    check("setclr_count", fifo_count, 4);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr_next_ovf", overflow, 0);

    // Re-arm overflow so reset has something to clear
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("rearm_ovf", overflow, 1);

    // Reset after 2 of 4 words; in_valid during reset is ignored
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("midrst_pre_word", bus.out_word, exp_word(1, 2));
    reset        = 1'b1;
    bus.in_block = mk(8);
    bus.in_valid = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_word", bus.out_word, 0);
    check("midrst_last", bus.out_last, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_afull", almost_full, 0);

    // Fresh block starts at word 0
    bus.in_block = FIPS;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check("fresh_word", bus.out_word, fips_w[w]);
      check("fresh_last", bus.out_last, (w == 3));
      tick();
    end
    check("fresh_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_output_serializer.md
Name: aes_output_serializer

Overview:
Sits directly downstream of the pipelined AES encoder/decoder. Captures every 128-bit result block presented with its valid strobe into a small block FIFO. Streams each block out as WORD_W-bit words over a valid/ready handshake. The cipher pipeline has no stall input, so this block absorbs bursts, reports occupancy, and flags dropped blocks.

Parameters:
DEPTH, 4, FIFO capacity in 128-bit blocks; power of 2, >= 2
WORD_W, 32, output word width; one of 8, 32, 64, 128; N = 128/WORD_W words per block

Ports:
clock  input  1  single clock for the whole block
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock
in_block  input  128  cipher output block (state_t flattened; byte 0 in [127:120])
in_valid  input  1  in_block holds a valid result this cycle (encodeValid/decodeValid)
out_word  output  WORD_W  current output word
out_valid  output  1  out_word is valid
out_ready  input  1  downstream accepts out_word this cycle
out_last  output  1  out_word is the final word of its block
fifo_count  output  $clog2(DEPTH)+1  number of blocks held, including the partially sent block
almost_full  output  1  fifo_count >= DEPTH-1
overflow  output  1  sticky: at least one block was dropped
clear_overflow  input  1  clears overflow

Behaviour:
- Reset, synchronous: rd_ptr, wr_ptr, fifo_count, word index and overflow all go to 0. After the reset edge: out_valid=0, out_word=0, out_last=0, almost_full=0. in_valid is ignored in any cycle with reset high. Reset in mid-block discards every stored block and any partial block; there is no recovery.
- Write: when in_valid=1, the block is accepted if fifo_count < DEPTH, or if a pop occurs in the same cycle. A pop is an out_valid & out_ready & out_last transfer. An accepted block is written to mem[wr_ptr] and wr_ptr advances mod DEPTH.
- Drop: if the block is not accepted, it is discarded, FIFO state is unchanged, and overflow is set on the next edge.
- Overflow: clear_overflow=1 clears it. If a set and a clear occur in the same cycle, the set wins.
- Latency: in_valid at edge k gives out_valid=1 after edge k, provided the FIFO was empty. This is 1 cycle, with no combinational in-to-out path.
- Output: out_valid = (fifo_count != 0). out_word = slice idx of mem[rd_ptr], MS slice first; idx 0 is bits [127:128-WORD_W]. out_last = out_valid & (idx == N-1). When out_valid=0, out_word is driven 0.
- Handshake: a transfer occurs when out_valid & out_ready. idx increments on each transfer. A transfer at idx N-1 resets idx to 0, advances rd_ptr mod DEPTH, and decrements the count.
- While out_valid=1 and out_ready=0, out_word and out_last hold stable. out_valid never drops without a transfer, except on reset.
- Simultaneous push and pop: the count is unchanged and the pointers both advance. This also applies when full.
- WORD_W=128: N=1, idx is constant 0, and every word has out_last=1.
- fifo_count is registered and always in the range 0..DEPTH.

Decomposition:
- AESDefinitions package: add AES_BLOCK_BITS=128. Reuse state_t.
- Sub-module aes_block_fifo: generic DEPTH x 128 storage with pointers and count, push/pop ports, full/empty outputs.
- The top level holds the accept/drop logic, the overflow flag, and the idx counter with slice selection.

Test Plan:
- FIPS-197 block: in_block=0x3925841d02dc09fbdc118597196a0b32, out_ready=1, WORD_W=32 -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles starting 1 cycle after in_valid; out_last only on 196a0b32; fifo_count returns to 0.
- Backpressure: out_ready low for 3 cycles mid-block (idx=1) -> out_word holds 02dc09fb and out_valid stays 1; streaming resumes on re-assert with no loss or duplication.
- Burst overflow: DEPTH=4, out_ready=0, 5 consecutive in_valid blocks -> fifo_count=4, almost_full=1 after the 3rd block, 5th dropped, overflow=1. Draining yields exactly blocks 1-4 in order.
- Full with concurrent pop: FIFO full, out_ready=1 at idx=3 (out_last), in_valid=1 in the same cycle -> block accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-block: reset asserted after 2 of 4 words -> next cycle out_valid=0, fifo_count=0, overflow=0. A fresh block then streams from word 0.
- Clear versus set: clear_overflow=1 in the same cycle as a drop -> overflow stays 1. clear_overflow alone on the next cycle -> overflow=0.
